// File: rtl/feature_stream_sequencer.sv
// Steps the 5-feature parallel-to-serial streamer through sample indices 1..NUM_SAMPLES,
// gating each frame on neuron-layer readiness and flagging frames that never complete.
module feature_stream_sequencer #(
    parameter int unsigned NUM_SAMPLES = 665,
    parameter int unsigned IDX_W       = 10,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             stop,
    input  logic             nn_ready,
    input  logic             ps_busy,
    input  logic             ps_valid,
    output logic             ps_start,
    output logic [IDX_W-1:0] ps_switch,
    output logic             frame_done,
    output logic [IDX_W-1:0] frame_count,
    output logic             running,
    output logic             done,
    output logic             err_timeout
);

    localparam int unsigned      TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SAMPLES);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] idx_n;
    logic [IDX_W-1:0] count_n;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_n;
    logic             stop_pending;
    logic             stop_pending_n;
    logic             halt;
    logic             frame_done_n;
    logic             start_c;

    // Start is decoded in the ISSUE cycle itself so the index and strobe line up.
    assign ps_start = start_c & ~rst;

    // Next-state and next-output decode.
    always_comb begin
        state_n        = state;
        idx_n          = ps_switch;
        count_n        = frame_count;
        timer_n        = timer;
        stop_pending_n = stop_pending;
        frame_done_n   = 1'b0;
        start_c        = 1'b0;
        halt           = stop_pending | stop;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    state_n        = S_ISSUE;
                    idx_n          = IDX_W'(1);
                    count_n        = '0;
                    stop_pending_n = 1'b0;
                end
            end
            S_ISSUE: begin
                if (halt) begin
                    state_n        = S_IDLE;
                    stop_pending_n = 1'b0;
                end else if (nn_ready && !ps_busy) begin
                    start_c = 1'b1;
                    state_n = S_STREAM;
                    timer_n = TMR_W'(1);
                end
            end
            S_STREAM: begin
                // A valid on the last timer cycle still completes the frame.
                if (ps_valid) begin
                    frame_done_n = 1'b1;
                    if (frame_count < LAST_IDX) begin
                        count_n = frame_count + IDX_W'(1);
                    end
                    if (ps_switch == LAST_IDX) begin
                        state_n        = S_DONE;
                        stop_pending_n = 1'b0;
                    end else if (halt) begin
                        state_n        = S_IDLE;
                        stop_pending_n = 1'b0;
                    end else begin
                        state_n = S_ISSUE;
                        idx_n   = ps_switch + IDX_W'(1);
                    end
                end else if (timer >= TMR_LIMIT) begin
                    state_n = S_ERR;
                end else begin
                    timer_n        = timer + TMR_W'(1);
                    stop_pending_n = halt;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ps_switch    <= '0;
            frame_count  <= '0;
            timer        <= '0;
            stop_pending <= 1'b0;
            frame_done   <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            ps_switch    <= idx_n;
            frame_count  <= count_n;
            timer        <= timer_n;
            stop_pending <= stop_pending_n;
            frame_done   <= frame_done_n;
            running      <= (state_n == S_ISSUE) || (state_n == S_STREAM);
            done         <= (state_n == S_DONE);
            err_timeout  <= (state_n == S_ERR);
        end
    end

endmodule

// File: tb/tb_feature_stream_sequencer.sv
// Bench for feature_stream_sequencer: streamer/neuron environment, run-level reference
// model compared every cycle, directed scenarios with literal expectations, random phase.
module tb_feature_stream_sequencer;

    localparam int unsigned N  = 5;
    localparam int unsigned IW = 10;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst, go, stop, nn_ready, ps_busy, ps_valid;
    logic          ps_start, frame_done, running, done, err_timeout;
    logic [IW-1:0] ps_switch, frame_count;

    always #5 clk = ~clk;

    feature_stream_sequencer #(.NUM_SAMPLES(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .nn_ready(nn_ready),
        .ps_busy(ps_busy), .ps_valid(ps_valid), .ps_start(ps_start),
        .ps_switch(ps_switch), .frame_done(frame_done), .frame_count(frame_count),
        .running(running), .done(done), .err_timeout(err_timeout)
    );

    int errs = 0;
    int checks = 0;

    // run-level model: a run is active, a frame may be open, a halt may be requested
    bit m_run = 0, m_open = 0, m_halt = 0, m_fin = 0, m_hung = 0, m_fd = 0;
    int m_age = 0, m_idx = 0, m_cnt = 0;

    // streamer environment
    int env_t = 0, env_b = 6, env_len = 6, hang_idx = -1;
    bit env_hang = 0, rand_env = 0;

    // observations
    int cyc = 0, n_start = 0, n_fd = 0, err_cyc = -1;
    int st_sw[$];
    int st_cyc[$];
    bit prev_start = 0, prev_err = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic m_step(input bit g, input bit s, input bit r, input bit rs, input bit v, input bit b);
        if (rs) begin
            m_run = 0; m_open = 0; m_halt = 0; m_fin = 0; m_hung = 0; m_fd = 0;
            m_idx = 0; m_cnt = 0;
        end else begin
            m_fd = 0;
            if (!m_run) begin
                if (g) begin
                    m_run = 1; m_open = 0; m_halt = 0; m_fin = 0; m_hung = 0;
                    m_idx = 1; m_cnt = 0;
                end
            end else if (!m_open) begin
                if (m_halt || s) begin
                    m_run = 0; m_halt = 0;
                end else if (r && !b) begin
                    m_open = 1; m_age = 0;
                end
            end else begin
                m_age++;
                if (v) begin
                    m_fd = 1; m_open = 0;
                    if (m_cnt < N) m_cnt++;
                    if (m_idx == N) begin
                        m_run = 0; m_fin = 1; m_halt = 0;
                    end else if (m_halt || s) begin
                        m_run = 0; m_halt = 0;
                    end else begin
                        m_idx++;
                    end
                end else if (m_age == TO) begin
                    m_run = 0; m_open = 0; m_hung = 1;
                end else begin
                    m_halt = m_halt || s;
                end
            end
        end
    endtask

    // One cycle: drive inputs at negedge, compare, advance model and streamer.
    task automatic tick(input bit g, input bit s, input bit r, input bit rs, input bit fv);
        bit b, v, es;
        b = (env_t >= 1) && (env_t <= env_b);
        v = fv || (!env_hang && (env_t == env_b + 1));
        go = g; stop = s; nn_ready = r; rst = rs; ps_busy = b; ps_valid = v;
        #1;
        es = m_run && !m_open && !(m_halt || s) && r && !b && !rs;
        chk("ps_start", ps_start, es);
        chk("ps_switch", ps_switch, m_idx);
        chk("frame_count", frame_count, m_cnt);
        chk("frame_done", frame_done, m_fd);
        chk("running", running, m_run);
        chk("done", done, m_fin && !m_run);
        chk("err_timeout", err_timeout, m_hung && !m_run);
        chk("start_width", ps_start & prev_start, 0);
        if (ps_start) begin
            n_start++;
            st_sw.push_back(int'(ps_switch));
            st_cyc.push_back(cyc);
        end
        if (frame_done) n_fd++;
        if (err_timeout && !prev_err) err_cyc = cyc;
        prev_start = ps_start;
        prev_err = err_timeout;
        m_step(g, s, r, rs, v, b);
        if (ps_start) begin
            env_t = 1;
            env_b = (env_len > 0) ? env_len : int'($urandom_range(16, 1));
            env_hang = (int'(ps_switch) == hang_idx) || (rand_env && ($urandom_range(19, 0) == 0));
        end else if (env_t > 0) begin
            env_t++;
            if (env_t > env_b + 1) env_t = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        n_start = 0; n_fd = 0; err_cyc = -1;
        st_sw.delete();
        st_cyc.delete();
    endtask

    task automatic run_to_end(input string nm, input int budget);
        int k;
        k = 0;
        while (running && k < budget) begin
            tick(0, 0, 1, 0, 0);
            k++;
        end
        chk(nm, running, 0);
        repeat (2) tick(0, 0, 1, 0, 0);
    endtask

    task automatic wait_start(input string nm, input int k, input int budget);
        int i;
        i = 0;
        while (n_start < k && i < budget) begin
            tick(0, 0, 1, 0, 0);
            i++;
        end
        chk(nm, n_start, k);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        go = 0; stop = 0; nn_ready = 1; rst = 1; ps_busy = 0; ps_valid = 0;
        repeat (2) @(negedge clk);
        repeat (2) tick(0, 0, 1, 1, 0);
        chk("rst_switch", ps_switch, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);

        // nominal run, 6-cycle busy
        clear_obs();
        tick(1, 0, 1, 0, 0);
        run_to_end("s1_end", 200);
        chk("s1_starts", n_start, 5);
        for (int i = 0; i < st_sw.size(); i++) chk("s1_switch", st_sw[i], i + 1);
        for (int i = 1; i < st_cyc.size(); i++) chk("s1_gap", st_cyc[i] - st_cyc[i-1], 8);
        chk("s1_frame_done", n_fd, 5);
        chk("s1_count", frame_count, 5);
        chk("s1_done", done, 1);

        // neuron layer not ready for 10 ISSUE cycles before frame 2
        clear_obs();
        tick(1, 0, 1, 0, 0);
        wait_start("s2_first", 1, 20);
        repeat (17) tick(0, 0, 0, 0, 0);
        run_to_end("s2_end", 200);
        chk("s2_gap", (st_cyc.size() >= 2) ? st_cyc[1] - st_cyc[0] : -1, 18);
        chk("s2_count", frame_count, 5);

        // streamer hangs on index 2
        hang_idx = 2;
        clear_obs();
        tick(1, 0, 1, 0, 0);
        run_to_end("s3_end", 200);
        chk("s3_err_delay", (st_cyc.size() >= 2) ? err_cyc - st_cyc[1] : -1, TO + 1);
        chk("s3_err", err_timeout, 1);
        chk("s3_switch", ps_switch, 2);
        chk("s3_count", frame_count, 1);
        hang_idx = -1;
        tick(0, 0, 1, 0, 1);
        repeat (4) tick(0, 0, 1, 0, 0);
        clear_obs();
        tick(1, 0, 1, 0, 0);
        chk("s3_err_clr", err_timeout, 0);
        run_to_end("s3_rerun", 200);
        chk("s3_restart_idx", (st_sw.size() > 0) ? st_sw[0] : -1, 1);
        chk("s3_rerun_done", done, 1);

        // stop during busy of frame 2
        clear_obs();
        tick(1, 0, 1, 0, 0);
        wait_start("s4_second", 2, 40);
        repeat (3) tick(0, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        run_to_end("s4_end", 100);
        repeat (40) tick(0, 0, 1, 0, 0);
        chk("s4_starts", n_start, 2);
        chk("s4_count", frame_count, 2);
        chk("s4_done", done, 0);
        tick(0, 0, 1, 0, 1);
        tick(0, 0, 1, 0, 0);
        chk("s4_idle_valid", frame_count, 2);

        // reset in the middle of frame 1; go+stop together in IDLE
        clear_obs();
        tick(1, 1, 1, 0, 0);
        wait_start("s5_first", 1, 20);
        repeat (3) tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        chk("s5_rst_switch", ps_switch, 0);
        chk("s5_rst_running", running, 0);
        repeat (10) tick(0, 0, 1, 0, 0);
        chk("s5_late_valid", frame_count, 0);
        chk("s5_no_fd", n_fd, 0);
        clear_obs();
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        repeat (3) tick(1, 0, 1, 0, 0);
        run_to_end("s5_end", 200);
        chk("s5_restart_idx", (st_sw.size() > 0) ? st_sw[0] : -1, 1);
        chk("s5_starts", n_start, 5);
        chk("s5_count", frame_count, 5);

        // randomized traffic
        rand_env = 1;
        env_len = 0;
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(39, 0) == 0, $urandom_range(149, 0) == 0,
                 $urandom_range(4, 0) != 0, $urandom_range(799, 0) == 0,
                 (env_t == 0) && ($urandom_range(59, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
